// File: rtl/as_seq_mac_alu.sv
// Fixed-point ADD / MUL / MAC / BR-offset ALU with an accumulator and a sequential shift-add multiplier.
// Optional clamping on overflow is enabled by defining SATURATE_EN; the default build wraps.
module as_seq_mac_alu #(
   parameter int N    = 8,
   parameter int FRAC = N - 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic         acc_wr,
   input  logic [N-1:0] rd_data,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] immediate,
   input  logic [N:0]   switches,
   input  logic         in_en,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] w_data,
   output logic [N-1:0] acc_out,
   output logic         z,
   output logic         neg,
   output logic         v
);

   typedef enum logic [1:0] {IDLE, MULT, FIN} state_t;

   typedef struct packed {
      logic [N-1:0] val;
      logic         ov;
   } res_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_MAC = 2'b10;
   localparam logic [1:0] OP_BR  = 2'b11;
   localparam int         CW     = $clog2(N + 1);

`ifdef SATURATE_EN
   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
`endif

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2*N-1:0]  mcand;
   logic [N-1:0]    mplier;
   logic [2*N-1:0]  prod;
   logic            prod_neg;
   logic [1:0]      op_q;
   logic            acc_wr_q;
   logic [N-1:0]    result_q;

   // N-bit signed add; the true sign on overflow is the common sign of the operands.
   function automatic res_t add_sat(input logic [N-1:0] a, input logic [N-1:0] b);
      res_t r;
      r.val = a + b;
      r.ov  = (a[N-1] == b[N-1]) && (r.val[N-1] != a[N-1]);
`ifdef SATURATE_EN
      if (r.ov) r.val = a[N-1] ? SAT_MIN : SAT_MAX;
`endif
      return r;
   endfunction

   logic [N-1:0]   add_a;
   logic [N-1:0]   rs_abs;
   logic [N-1:0]   imm_abs;
   logic [2*N-1:0] prod_next;
   logic [2*N-1:0] p_full;
   logic [2*N-1:0] p_sh;
   res_t           add_r;
   res_t           mul_r;
   res_t           mac_r;
   res_t           fin_r;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      add_a     = (op == OP_BR) ? {N{switches[N]}} : rd_data;
      add_r     = add_sat(add_a, immediate);
      rs_abs    = rs_data[N-1] ? -rs_data : rs_data;
      imm_abs   = immediate[N-1] ? -immediate : immediate;

      prod_next = prod + (mplier[0] ? mcand : '0);
      p_full    = prod_neg ? -prod_next : prod_next;
      p_sh      = $signed(p_full) >>> FRAC;
      mul_r.val = p_sh[N-1:0];
      mul_r.ov  = p_sh != {{N{p_sh[N-1]}}, p_sh[N-1:0]};
`ifdef SATURATE_EN
      if (mul_r.ov) mul_r.val = p_full[2*N-1] ? SAT_MIN : SAT_MAX;
`endif
      mac_r     = add_sat(acc_out, mul_r.val);
      mac_r.ov  = mac_r.ov | mul_r.ov;
      fin_r     = (op_q == OP_MAC) ? mac_r : mul_r;
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         prod     <= '0;
         prod_neg <= 1'b0;
         op_q     <= OP_ADD;
         acc_wr_q <= 1'b0;
         result_q <= '0;
         acc_out  <= '0;
         z        <= 1'b0;
         neg      <= 1'b0;
         v        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_q     <= op;
                  acc_wr_q <= acc_wr;
                  if (op == OP_MUL || op == OP_MAC) begin
                     mcand    <= {{N{1'b0}}, rs_abs};
                     mplier   <= imm_abs;
                     prod     <= '0;
                     prod_neg <= rs_data[N-1] ^ immediate[N-1];
                     cnt      <= '0;
                     busy     <= 1'b1;
                     state    <= MULT;
                  end else begin
                     result_q <= add_r.val;
                     z        <= (add_r.val == '0);
                     neg      <= add_r.val[N-1];
                     v        <= add_r.ov;
                     if (acc_wr) acc_out <= add_r.val;
                     done     <= 1'b1;
                     state    <= FIN;
                  end
               end
            end
            MULT: begin
               prod   <= prod_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // The Nth partial product is folded in combinationally so the result lands on this edge.
               if (cnt == CW'(N - 1)) begin
                  result_q <= fin_r.val;
                  z        <= (fin_r.val == '0);
                  neg      <= fin_r.val[N-1];
                  v        <= fin_r.ov;
                  if (op_q == OP_MAC || acc_wr_q) acc_out <= fin_r.val;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign w_data = in_en ? switches[N-1:0] : result_q;

endmodule

// File: tb/tb_as_seq_mac_alu.sv
// Directed self-checking bench for as_seq_mac_alu (N=8, FRAC=7); expectations follow SATURATE_EN when defined.
module tb_as_seq_mac_alu;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] op;
   logic       acc_wr;
   logic [7:0] rd_data;
   logic [7:0] rs_data;
   logic [7:0] immediate;
   logic [8:0] switches;
   logic       in_en;
   logic       busy;
   logic       done;
   logic [7:0] w_data;
   logic [7:0] acc_out;
   logic       z;
   logic       neg;
   logic       v;

   int checks = 0;
   int errors = 0;

   as_seq_mac_alu #(.N(8), .FRAC(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .acc_wr    (acc_wr),
      .rd_data   (rd_data),
      .rs_data   (rs_data),
      .immediate (immediate),
      .switches  (switches),
      .in_en     (in_en),
      .busy      (busy),
      .done      (done),
      .w_data    (w_data),
      .acc_out   (acc_out),
      .z         (z),
      .neg       (neg),
      .v         (v)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one op, measures start-to-done latency, then steps into IDLE so the next start is accepted.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] rd, input logic [7:0] rs,
                         input logic [7:0] imm, input logic [8:0] sw, input logic aw, input int exp_lat);
      int lat;
      op = o; rd_data = rd; rs_data = rs; immediate = imm; switches = sw; acc_wr = aw;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      if (exp_lat > 1) check({tag, "_busy"}, busy, 1);
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      tick();
   endtask

   task automatic check_res(input string tag, input logic [7:0] w, input logic fz, input logic fn, input logic fv);
      check({tag, "_w"},   w_data, w);
      check({tag, "_z"},   z,      fz);
      check({tag, "_neg"}, neg,    fn);
      check({tag, "_v"},   v,      fv);
   endtask

   initial begin
      int lat;
      int extra_done;
      reset = 1'b1; start = 1'b0; op = 2'b00; acc_wr = 1'b0;
      rd_data = '0; rs_data = '0; immediate = '0; switches = '0; in_en = 1'b0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
      check("rst_acc", acc_out, 0);
      reset = 1'b0;
      tick();

      // 0.5 * 0.5 = 0.25
      run_op("mul_pos", 2'b01, 8'h00, 8'h40, 8'h40, 9'h000, 1'b0, 9);
      check_res("mul_pos", 8'h20, 1'b0, 1'b0, 1'b0);
      check("mul_pos_acc", acc_out, 8'h00);

      // -1 * -1 = +1 is not representable
      run_op("mul_ovf", 2'b01, 8'h00, 8'h80, 8'h80, 9'h000, 1'b0, 9);
`ifdef SATURATE_EN
      check_res("mul_ovf", 8'h7F, 1'b0, 1'b0, 1'b1);
`else
      check_res("mul_ovf", 8'h80, 1'b0, 1'b1, 1'b1);
`endif

      // -0.5 * 0.5 = -0.25
      run_op("mul_neg", 2'b01, 8'h00, 8'hC0, 8'h40, 9'h000, 1'b0, 9);
      check_res("mul_neg", 8'hE0, 1'b0, 1'b1, 1'b0);

      run_op("add_ovf", 2'b00, 8'h7F, 8'h00, 8'h01, 9'h000, 1'b0, 1);
`ifdef SATURATE_EN
      check_res("add_ovf", 8'h7F, 1'b0, 1'b0, 1'b1);
`else
      check_res("add_ovf", 8'h80, 1'b0, 1'b1, 1'b1);
`endif

      run_op("add_zero", 2'b00, 8'h05, 8'h00, 8'hFB, 9'h000, 1'b0, 1);
      check_res("add_zero", 8'h00, 1'b1, 1'b0, 1'b0);

      run_op("br_taken", 2'b11, 8'h00, 8'h00, 8'h03, 9'h100, 1'b0, 1);
      check_res("br_taken", 8'h02, 1'b0, 1'b0, 1'b0);
      run_op("br_not", 2'b11, 8'h00, 8'h00, 8'h03, 9'h000, 1'b0, 1);
      check_res("br_not", 8'h03, 1'b0, 1'b0, 1'b0);
      check("br_acc", acc_out, 8'h00);

      run_op("mac1", 2'b10, 8'h00, 8'h40, 8'h40, 9'h000, 1'b0, 9);
      check("mac1_acc", acc_out, 8'h20);

      // Second MAC with a stray start pulse in its third busy cycle.
      op = 2'b10; rs_data = 8'h40; immediate = 8'h40;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      tick(); tick();
      lat += 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("mac2_lat", lat, 9);
      check("mac2_acc", acc_out, 8'h40);
      check_res("mac2", 8'h40, 1'b0, 1'b0, 1'b0);
      extra_done = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) extra_done++;
      end
      check("mac2_no_third", extra_done, 0);
      check("mac2_acc_hold", acc_out, 8'h40);

      run_op("add_accwr", 2'b00, 8'h10, 8'h00, 8'h22, 9'h000, 1'b1, 1);
      check_res("add_accwr", 8'h32, 1'b0, 1'b0, 1'b0);
      check("add_accwr_acc", acc_out, 8'h32);

      switches = 9'h0A5;
      in_en = 1'b1;
      #1;
      check("in_en_w", w_data, 8'hA5);
      in_en = 1'b0;
      #1;
      check("in_en_off_w", w_data, 8'h32);

      // Reset during the third MULT cycle discards the operation.
      op = 2'b01; rs_data = 8'h40; immediate = 8'h40; switches = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_acc", acc_out, 0);
      check("midrst_w", w_data, 0);
      reset = 1'b0;
      tick();

      // 0.75 * 0.5 = 0.375
      run_op("mul_after_rst", 2'b01, 8'h00, 8'h60, 8'h40, 9'h000, 1'b0, 9);
      check_res("mul_after_rst", 8'h30, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
